// File: rtl/xg_mac_pkg.sv
// Shared types and widths for the 10G MAC datapath blocks (TX arbiter, RX distributor).
// Beat layout and the arbiter state encoding live here so sub-blocks agree on them.
package xg_mac_pkg;

  localparam int XG_DATA_W = 64;
  localparam int XG_KEEP_W = 8;

  typedef struct packed {
    logic [XG_DATA_W-1:0] tdata;
    logic [XG_KEEP_W-1:0] tkeep;
    logic                 tuser;
    logic                 tlast;
  } axis_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/xg_mac_rr_picker.sv
// Combinational rotate-priority encoder: returns the first requester after 'last',
// wrapping around. Shared by the TX arbiter and the RX distributor.
module xg_mac_rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [PORT_W-1:0]    pick,
  output logic                 any
);

  localparam int IW = PORT_W + 1;

  logic [IW-1:0] idx;

  // NOTE: every signal written here gets a default before any branch, so no latch is
  // inferred; blocking '=' is correct in combinational logic because idx is a scratch value.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = IW'(last) + IW'(i);
      if (idx >= IW'(NUM_PORTS)) idx = idx - IW'(NUM_PORTS);
      if (req[idx[PORT_W-1:0]]) pick = idx[PORT_W-1:0];
    end
  end

endmodule

// File: rtl/xg_mac_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the 10G MAC TX AXI-Stream slave.
// Define XG_MAC_TX_ARB_PRIORITY_EN to give port 0 strict priority over the round robin.
module xg_mac_tx_arbiter
  import xg_mac_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           port_enable,
  input  logic [NUM_PORTS*XG_DATA_W-1:0] saxis_tdata,
  input  logic [NUM_PORTS-1:0]           saxis_tvalid,
  output logic [NUM_PORTS-1:0]           saxis_tready,
  input  logic [NUM_PORTS*XG_KEEP_W-1:0] saxis_tkeep,
  input  logic [NUM_PORTS-1:0]           saxis_tuser,
  input  logic [NUM_PORTS-1:0]           saxis_tlast,
  output logic [XG_DATA_W-1:0]           maxis_tdata,
  output logic                           maxis_tvalid,
  input  logic                           maxis_tready,
  output logic [XG_KEEP_W-1:0]           maxis_tkeep,
  output logic                           maxis_tuser,
  output logic                           maxis_tlast,
  output logic                           grant_valid,
  output logic [PORT_W-1:0]              grant_index
);

  arb_state_t           state_q, state_d;
  logic [PORT_W-1:0]    grant_index_q, grant_index_d;
  logic [PORT_W-1:0]    last_q, last_d;
  logic [NUM_PORTS-1:0] req;
  logic [PORT_W-1:0]    pick;
  logic                 any;
  logic                 upd_last;
  axis_beat_t           beat;

  assign req = saxis_tvalid & port_enable;

`ifdef XG_MAC_TX_ARB_PRIORITY_EN
  logic [NUM_PORTS-1:0] rr_req;
  logic [PORT_W-1:0]    rr_pick;
  logic                 rr_any;

  assign rr_req = {req[NUM_PORTS-1:1], 1'b0};

  xg_mac_rr_picker #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_picker (
    .req  (rr_req),
    .last (last_q),
    .pick (rr_pick),
    .any  (rr_any)
  );

  // Port 0 pre-empts the rotation and leaves the pointer where the other ports left it.
  always_comb begin
    pick     = req[0] ? '0 : rr_pick;
    any      = req[0] | rr_any;
    upd_last = ~req[0];
  end
`else
  xg_mac_rr_picker #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_picker (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign upd_last = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    last_d        = last_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d       = BUSY;
          grant_index_d = pick;
          if (upd_last) last_d = pick;
        end
      end
      BUSY: begin
        if (maxis_tvalid && maxis_tready && maxis_tlast) state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_index_q <= '0;
      last_q        <= PORT_W'(NUM_PORTS - 1);
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      last_q        <= last_d;
    end
  end

  // Storage-free pass-through: backpressure and valid travel combinationally in BUSY.
  always_comb begin
    saxis_tready = '0;
    maxis_tvalid = 1'b0;
    beat         = '0;
    if (state_q == BUSY) begin
      maxis_tvalid                = saxis_tvalid[grant_index_q];
      saxis_tready[grant_index_q] = maxis_tready;
      beat.tdata = saxis_tdata[XG_DATA_W*grant_index_q +: XG_DATA_W];
      beat.tkeep = saxis_tkeep[XG_KEEP_W*grant_index_q +: XG_KEEP_W];
      beat.tuser = saxis_tuser[grant_index_q];
      beat.tlast = saxis_tlast[grant_index_q];
    end
  end

  assign maxis_tdata = beat.tdata;
  assign maxis_tkeep = beat.tkeep;
  assign maxis_tuser = beat.tuser;
  assign maxis_tlast = beat.tlast;
  assign grant_valid = (state_q == BUSY);
  assign grant_index = grant_index_q;

endmodule

// File: tb/tb_xg_mac_tx_arbiter.sv
// Self-checking bench for xg_mac_tx_arbiter: frame-level arbitration model plus a beat
// scoreboard, directed scenarios and a randomized run with backpressure and valid gaps.
module tb_xg_mac_tx_arbiter;
  import xg_mac_pkg::*;

  localparam int NP = 4;
  localparam int PW = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NP-1:0]           port_enable;
  logic [NP*XG_DATA_W-1:0] saxis_tdata;
  logic [NP-1:0]           saxis_tvalid;
  logic [NP-1:0]           saxis_tready;
  logic [NP*XG_KEEP_W-1:0] saxis_tkeep;
  logic [NP-1:0]           saxis_tuser;
  logic [NP-1:0]           saxis_tlast;
  logic [XG_DATA_W-1:0]    maxis_tdata;
  logic                    maxis_tvalid;
  logic                    maxis_tready;
  logic [XG_KEEP_W-1:0]    maxis_tkeep;
  logic                    maxis_tuser;
  logic                    maxis_tlast;
  logic                    grant_valid;
  logic [PW-1:0]           grant_index;

  xg_mac_tx_arbiter #(.NUM_PORTS(NP)) dut (
    .clock        (clock),
    .reset        (reset),
    .port_enable  (port_enable),
    .saxis_tdata  (saxis_tdata),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tready (saxis_tready),
    .saxis_tkeep  (saxis_tkeep),
    .saxis_tuser  (saxis_tuser),
    .saxis_tlast  (saxis_tlast),
    .maxis_tdata  (maxis_tdata),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tready (maxis_tready),
    .maxis_tkeep  (maxis_tkeep),
    .maxis_tuser  (maxis_tuser),
    .maxis_tlast  (maxis_tlast),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index)
  );

  always #5 clock = ~clock;

  // Source queues (what each upstream still has to send) and the model's own copy.
  axis_beat_t src_q[NP][$];
  axis_beat_t mdl_q[NP][$];
  bit         src_mid[NP];
  bit         in_frame;
  int         cur;
  int         mdl_last;
  int         bubble_cnt;
  int         beats_seen;
  int         grant_log[$];
  bit [1:0]   trace[$];
  int         ready_mode;
  bit         ready_phase;
  bit         drop_en;
  int         vectors;
  int         errors;

  function automatic bit work_left();
    bit w = 1'b0;
    for (int p = 0; p < NP; p++) if (mdl_q[p].size() != 0) w = 1'b1;
    return w;
  endfunction

  // Frame-level arbitration rule: next pending port after the last winner, wrapping.
  function automatic int model_pick(bit [NP-1:0] pend);
    int  p     = -1;
    bit  found = 1'b0;
`ifdef XG_MAC_TX_ARB_PRIORITY_EN
    if (pend[0]) return 0;
`endif
    for (int k = 1; k <= NP; k++) begin
      int c = (mdl_last + k) % NP;
`ifdef XG_MAC_TX_ARB_PRIORITY_EN
      if (c == 0) continue;
`endif
      if (!found && pend[c]) begin
        p     = c;
        found = 1'b1;
      end
    end
    if (found) mdl_last = p;
    return p;
  endfunction

  task automatic add_frame(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      axis_beat_t b;
      b.tdata = {$urandom(), $urandom()};
      b.tkeep = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.tuser = (i == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      b.tlast = (i == len - 1);
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      axis_beat_t b;
      bit         v;
      if (src_q[p].size() != 0) begin
        b = src_q[p][0];
        v = !(drop_en && src_mid[p] && ($urandom_range(0, 2) == 0));
      end else begin
        b = '0;
        v = 1'b0;
      end
      saxis_tdata[XG_DATA_W*p +: XG_DATA_W] = b.tdata;
      saxis_tkeep[XG_KEEP_W*p +: XG_KEEP_W] = b.tkeep;
      saxis_tuser[p]  = b.tuser;
      saxis_tlast[p]  = b.tlast;
      saxis_tvalid[p] = v;
    end
    case (ready_mode)
      0: maxis_tready = 1'b1;
      1: begin
        maxis_tready = ready_phase;
        ready_phase  = ~ready_phase;
      end
      default: maxis_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // One clock: sample at negedge, check against the model, retire handshakes, drive.
  task automatic step();
    bit [NP-1:0] pend;
    @(negedge clock);
    for (int p = 0; p < NP; p++) pend[p] = (mdl_q[p].size() != 0) && port_enable[p];
    trace.push_back({maxis_tvalid, maxis_tvalid & maxis_tlast});
    if (!in_frame) begin
      if (maxis_tvalid) begin
        vectors++;
        if (pend == '0) begin
          errors++;
          $display("FAIL spurious_valid: maxis_tvalid=1 with no pending frame");
        end else begin
          cur      = model_pick(pend);
          in_frame = 1'b1;
          grant_log.push_back(cur);
          vectors++;
          if (bubble_cnt != 1) begin
            errors++;
            $display("FAIL bubble: %0d idle cycles before frame from port %0d, expected 1",
                     bubble_cnt, cur);
          end
        end
        bubble_cnt = 0;
      end else begin
        if (pend != '0) bubble_cnt++;
        vectors++;
        if (saxis_tready !== '0 || grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: saxis_tready=%b grant_valid=%b, expected 0000/0",
                   saxis_tready, grant_valid);
        end
      end
    end
    if (in_frame) begin
      bit [NP-1:0] exp_rdy;
      exp_rdy = maxis_tready ? (NP'(1) << cur) : '0;
      vectors++;
      if (grant_valid !== 1'b1 || grant_index !== PW'(cur) || saxis_tready !== exp_rdy ||
          maxis_tvalid !== saxis_tvalid[cur]) begin
        errors++;
        $display("FAIL grant: gv=%b gi=%0d rdy=%b mv=%b, expected gv=1 gi=%0d rdy=%b mv=%b",
                 grant_valid, grant_index, saxis_tready, maxis_tvalid, cur, exp_rdy,
                 saxis_tvalid[cur]);
      end
      if (maxis_tvalid && maxis_tready) begin
        axis_beat_t exp_b;
        beats_seen++;
        exp_b = (mdl_q[cur].size() != 0) ? mdl_q[cur].pop_front() : '0;
        vectors++;
        if (maxis_tdata !== exp_b.tdata || maxis_tkeep !== exp_b.tkeep ||
            maxis_tuser !== exp_b.tuser || maxis_tlast !== exp_b.tlast) begin
          errors++;
          $display("FAIL beat port%0d: got %h/%h/%b/%b expected %h/%h/%b/%b", cur,
                   maxis_tdata, maxis_tkeep, maxis_tuser, maxis_tlast,
                   exp_b.tdata, exp_b.tkeep, exp_b.tuser, exp_b.tlast);
        end
        if (exp_b.tlast) in_frame = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (saxis_tvalid[p] && saxis_tready[p] && src_q[p].size() != 0) begin
        src_mid[p] = !src_q[p][0].tlast;
        void'(src_q[p].pop_front());
      end
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic run_drain(input string name, input int budget);
    int n = 0;
    while ((work_left() || in_frame) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (work_left() || in_frame) begin
      errors++;
      $display("FAIL %s_timeout: frames still pending after %0d cycles, expected drained",
               name, budget);
    end
    repeat (2) step();
  endtask

  task automatic flush_model();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
      src_mid[p] = 1'b0;
    end
    in_frame   = 1'b0;
    mdl_last   = NP - 1;
    bubble_cnt = 0;
    beats_seen = 0;
    grant_log.delete();
    trace.delete();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    flush_model();
    port_enable = '1;
    ready_mode  = 0;
    drop_en     = 1'b0;
    drive();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_model();
    port_enable = '1;
    for (int p = 0; p < NP; p++) add_frame(p, 2);
    drive();
    @(negedge clock);
    vectors++;
    if (saxis_tready !== '0 || maxis_tvalid !== 1'b0 || maxis_tdata !== '0 ||
        maxis_tkeep !== '0 || maxis_tuser !== 1'b0 || maxis_tlast !== 1'b0 ||
        grant_valid !== 1'b0 || grant_index !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b mv=%b d=%h k=%h u=%b l=%b gv=%b gi=%0d, expected all 0",
               saxis_tready, maxis_tvalid, maxis_tdata, maxis_tkeep, maxis_tuser,
               maxis_tlast, grant_valid, grant_index);
    end
  endtask

  task automatic test_all_ports();
    int exp_o[4] = '{0, 1, 2, 3};
    int f = -1;
    do_reset();
    for (int p = 0; p < NP; p++) add_frame(p, 3);
    drive();
    run_drain("all_ports", 200);
    for (int i = 0; i < 4; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != exp_o[i]) begin
        errors++;
        $display("FAIL all_ports_order[%0d]: got %0d expected %0d", i, got, exp_o[i]);
      end
    end
    for (int i = trace.size() - 1; i >= 0; i--) if (trace[i][1]) f = i;
    for (int c = 1; c <= 15; c++) begin
      bit [1:0] got = (f >= 0 && f + c - 1 < trace.size()) ? trace[f+c-1] : 2'b11;
      bit [1:0] exp = {(c % 4) != 0, (c % 4) == 3};
      vectors++;
      if (got != exp) begin
        errors++;
        $display("FAIL all_ports_cycle%0d: valid/last=%b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_enable();
    int exp_o[8] = '{0, 2, 3, 0, 2, 3, 0, 1};
    int n        = 0;
    bit en_set   = 1'b0;
    do_reset();
    port_enable = 4'b1101;
    add_frame(0, 3); add_frame(0, 3); add_frame(0, 3);
    add_frame(1, 3);
    add_frame(2, 3); add_frame(2, 3);
    add_frame(3, 3); add_frame(3, 3);
    drive();
    while ((work_left() || in_frame) && n < 600) begin
      if (!en_set && in_frame && grant_log.size() == 5) begin
        port_enable = 4'b1111;
        en_set      = 1'b1;
      end
      step();
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != exp_o[i]) begin
        errors++;
        $display("FAIL enable_order[%0d]: got %0d expected %0d", i, got, exp_o[i]);
      end
    end
    repeat (2) step();
  endtask

  task automatic test_single_port();
    bit exp_v[6] = '{0, 1, 1, 0, 1, 1};
    do_reset();
    add_frame(2, 2);
    add_frame(2, 2);
    drive();
    run_drain("single_port", 100);
    for (int i = 0; i < 6; i++) begin
      bit got = (i < trace.size()) ? trace[i][1] : 1'bx;
      vectors++;
      if (got !== exp_v[i]) begin
        errors++;
        $display("FAIL single_port_valid[%0d]: got %b expected %b", i, got, exp_v[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != 2) begin
        errors++;
        $display("FAIL single_port_grant[%0d]: got %0d expected 2", i, got);
      end
    end
  endtask

  task automatic test_tready_toggle();
    grant_log.delete();
    beats_seen  = 0;
    ready_mode  = 1;
    ready_phase = 1'b1;
    add_frame(1, 4);
    drive();
    run_drain("tready_toggle", 100);
    vectors++;
    if (beats_seen != 4 || grant_log.size() != 1 || grant_log[0] != 1) begin
      errors++;
      $display("FAIL tready_toggle: beats=%0d grants=%0d, expected 4 beats from port 1",
               beats_seen, grant_log.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_midframe();
    int exp_o[4] = '{0, 1, 2, 3};
    int n        = 0;
    ready_mode = 0;
    add_frame(1, 4);
    drive();
    while (src_q[1].size() != 3 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (src_q[1].size() != 3) begin
      errors++;
      $display("FAIL reset_mid_reach: beat 2 never presented, remaining=%0d expected 3",
               src_q[1].size());
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (saxis_tready !== '0 || maxis_tvalid !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%b mv=%b gv=%b, expected 0000/0/0",
               saxis_tready, maxis_tvalid, grant_valid);
    end
    flush_model();
    for (int p = 0; p < NP; p++) add_frame(p, 2);
    drive();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive();
    run_drain("reset_mid", 200);
    for (int i = 0; i < 4; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != exp_o[i]) begin
        errors++;
        $display("FAIL reset_mid_order[%0d]: got %0d expected %0d", i, got, exp_o[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      drop_en    = 1'b1;
      ready_mode = 2;
      for (int p = 0; p < NP; p++) begin
        int nf = $urandom_range(0, 3);
        for (int k = 0; k < nf; k++) add_frame(p, $urandom_range(1, 6));
      end
      drive();
      run_drain("random", 3000);
    end
    drop_en    = 1'b0;
    ready_mode = 0;
  endtask

`ifdef XG_MAC_TX_ARB_PRIORITY_EN
  task automatic test_priority();
    int exp_a[5] = '{0, 0, 0, 1, 1};
    int exp_b[4] = '{2, 1, 2, 1};
    do_reset();
    for (int k = 0; k < 3; k++) add_frame(0, 2);
    for (int k = 0; k < 2; k++) add_frame(1, 2);
    drive();
    run_drain("priority_a", 300);
    for (int i = 0; i < 5; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != exp_a[i]) begin
        errors++;
        $display("FAIL priority_order[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      add_frame(1, 2);
      add_frame(2, 2);
    end
    drive();
    run_drain("priority_b", 300);
    for (int i = 0; i < 4; i++) begin
      int got = (i < grant_log.size()) ? grant_log[i] : -1;
      vectors++;
      if (got != exp_b[i]) begin
        errors++;
        $display("FAIL priority_rr[%0d]: got %0d expected %0d", i, got, exp_b[i]);
      end
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    vectors      = 0;
    errors       = 0;
    port_enable  = '1;
    saxis_tdata  = '0;
    saxis_tkeep  = '0;
    saxis_tuser  = '0;
    saxis_tlast  = '0;
    saxis_tvalid = '0;
    maxis_tready = 1'b0;
    ready_mode   = 0;
    ready_phase  = 1'b1;
    drop_en      = 1'b0;
    test_reset();
    test_all_ports();
`ifndef XG_MAC_TX_ARB_PRIORITY_EN
    test_enable();
`endif
    test_single_port();
    test_tready_toggle();
    test_reset_midframe();
    test_random();
`ifdef XG_MAC_TX_ARB_PRIORITY_EN
    test_priority();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
